// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared VRAM constants and the CPU read-path state encoding. Imported by the
// arbiter and by the display controller so both agree on geometry and timing.
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

   localparam int VRAM_ADDR_W       = 13;  // 8192 words = 512x256 at 1 bpp
   localparam int VRAM_DATA_W       = 16;
   localparam int VRAM_READ_LATENCY = 3;   // display request -> vga_rdata, cycles

   // CPU read path: WAIT covers both "buffer still draining" and "slot lost to
   // a display read"; ISSUED is the single cycle between RAM access and return.
   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_WAIT   = 2'd1,
      RD_ISSUED = 2'd2
   } rd_state_t;

endpackage

// File: rtl/vram_arbiter_write_fifo.sv
// -----------------------------------------------------------------------------
// vram_write_fifo
// CPU write buffer with registered storage and show-ahead output.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   i_push, i_push_data - write an entry (ignored when full unless popping)
//   i_pop               - retire the head entry (ignored when empty)
//   o_pop_data          - current head entry
//   o_full, o_empty     - occupancy flags
// -----------------------------------------------------------------------------
module vram_write_fifo
   import vram_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = VRAM_ADDR_W + VRAM_DATA_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int               PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_full     = (r_count == FULL_COUNT);
   assign o_empty    = (r_count == {(PTR_W + 1){1'b0}});
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_pop_ok   = i_pop & ~o_empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign w_push_ok  = i_push & (~o_full | w_pop_ok);

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (!reset && w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Owns the single-port VRAM and shares its one access per cycle between the
// display (fixed 3-cycle read latency, highest priority), CPU reads (issued
// only once the write buffer is empty) and draining of buffered CPU writes.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   cpu_wren/cpu_waddr/cpu_wdata       - CPU write request (buffered)
//   cpu_rden/cpu_raddr                 - CPU read request
//   cpu_rdata/cpu_rvalid               - CPU read return (one-cycle pulse)
//   cpu_busy                           - CPU must hold its request while high
//   vga_rden/vga_raddr                 - display read request
//   vga_rdata                          - display read data, held until next
// -----------------------------------------------------------------------------
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = VRAM_ADDR_W,
   parameter int DATA_W     = VRAM_DATA_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_waddr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_rden,
   input  logic [ADDR_W-1:0] cpu_raddr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_busy,
   input  logic              vga_rden,
   input  logic [ADDR_W-1:0] vga_raddr,
   output logic [DATA_W-1:0] vga_rdata
);

   localparam int ENTRY_W = ADDR_W + DATA_W;

   logic [DATA_W-1:0]  r_ram [2**ADDR_W];
   logic [DATA_W-1:0]  r_ram_q;

   logic               r_vga_req;
   logic [ADDR_W-1:0]  r_vga_addr;
   logic               r_vga_q_vld;
   logic [DATA_W-1:0]  r_vga_rdata;

   rd_state_t          r_rd_state;
   logic [ADDR_W-1:0]  r_cpu_raddr;
   logic [DATA_W-1:0]  r_cpu_rdata;
   logic               r_cpu_rvalid;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_cpu_issue;
   logic [ENTRY_W-1:0] w_head;
   logic [ADDR_W-1:0]  w_ram_addr;
   logic [DATA_W-1:0]  w_ram_wdata;
   logic               w_ram_we;
   logic               w_ram_re;

   vram_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_wfifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data ({cpu_waddr, cpu_wdata}),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // RAM slot arbitration: display read, then CPU read, then buffer drain.
   // No write or CPU read is started while reset is asserted.
   always_comb begin
      w_pop       = 1'b0;
      w_cpu_issue = 1'b0;
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = r_vga_addr;
      w_ram_wdata = w_head[DATA_W-1:0];
      if (r_vga_req) begin
         w_ram_re   = 1'b1;
         w_ram_addr = r_vga_addr;
      end else if (reset) begin
         w_ram_re   = 1'b0;
      end else if ((r_rd_state == RD_WAIT) && w_empty) begin
         w_cpu_issue = 1'b1;
         w_ram_re    = 1'b1;
         w_ram_addr  = r_cpu_raddr;
      end else if (!w_empty) begin
         w_pop      = 1'b1;
         w_ram_we   = 1'b1;
         w_ram_addr = w_head[ENTRY_W-1:DATA_W];
      end else begin
         w_ram_re   = 1'b0;
      end
   end

   assign w_push = cpu_wren & (~w_full | w_pop);

   // Busy covers a write the buffer cannot take this cycle and a pending read.
   assign cpu_busy = ~reset & ((cpu_wren & w_full & ~w_pop) | (r_rd_state != RD_IDLE));

   assign vga_rdata  = r_vga_rdata;
   assign cpu_rdata  = r_cpu_rdata;
   assign cpu_rvalid = r_cpu_rvalid;

   // Single-port RAM with registered read data; never cleared by reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
      if (w_ram_re) r_ram_q <= r_ram[w_ram_addr];
   end

   // Display pipeline: request register, RAM read, output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vga_req   <= 1'b0;
         r_vga_addr  <= {ADDR_W{1'b0}};
         r_vga_q_vld <= 1'b0;
         r_vga_rdata <= {DATA_W{1'b0}};
      end else begin
         r_vga_req   <= vga_rden;
         r_vga_addr  <= vga_raddr;
         r_vga_q_vld <= r_vga_req;
         if (r_vga_q_vld) r_vga_rdata <= r_ram_q;
      end
   end

   // CPU read FSM; ISSUED lasts exactly one cycle, so rvalid lands two
   // cycles after the RAM slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_state   <= RD_IDLE;
         r_cpu_raddr  <= {ADDR_W{1'b0}};
         r_cpu_rdata  <= {DATA_W{1'b0}};
         r_cpu_rvalid <= 1'b0;
      end else begin
         r_cpu_rvalid <= 1'b0;
         case (r_rd_state)
            RD_IDLE: begin
               if (cpu_rden) begin
                  r_cpu_raddr <= cpu_raddr;
                  r_rd_state  <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (w_cpu_issue) r_rd_state <= RD_ISSUED;
            end
            RD_ISSUED: begin
               r_cpu_rdata  <= r_ram_q;
               r_cpu_rvalid <= 1'b1;
               r_rd_state   <= RD_IDLE;
            end
            default: r_rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule
